// File: rtl/yarvi_trace_ctrl.sv
// yarvi_trace_ctrl: captures yarvi retire records into a circular FIFO and
// serializes each one as a little-endian byte stream over a valid/ready port.
module yarvi_trace_ctrl #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [1:0]             prv,
  input  logic [XLEN-1:0]        pc,
  input  logic [31:0]            insn,
  input  logic                   we,
  input  logic [4:0]             addr,
  input  logic [XLEN-1:0]        d,
  input  logic                   enable,
  input  logic                   clr_dropped,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             dropped,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int XB = XLEN / 8;
  localparam int IW = ($clog2(XB) < 2) ? 2 : $clog2(XB);
  localparam logic [IW-1:0] PC_LAST   = IW'(XB - 1);
  localparam logic [IW-1:0] INSN_LAST = IW'(3);

  typedef struct packed {
    logic [1:0]      prv;
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [XLEN-1:0] d;
  } rec_t;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_INSN, S_DATA} state_t;

  rec_t          mem [DEPTH];
  rec_t          in_rec;
  rec_t          hold;
  state_t        state;
  logic [IW-1:0] idx;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          pop;

  // Full is judged on the registered level, so a same-cycle pop never rescues a record.
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign push  = valid & enable & ~full;
  assign drop  = valid & enable & full;
  assign pop   = (state == S_IDLE) & ~empty;

  always_comb begin
    in_rec      = '0;
    in_rec.prv  = prv;
    in_rec.we   = we;
    in_rec.addr = addr;
    in_rec.pc   = pc;
    in_rec.insn = insn;
    in_rec.d    = we ? d : '0;
  end

  // NOTE: storage array has no reset; only pointers and level define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_rec;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A clear wins over the running count but still records a drop in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped <= '0;
    end else if (clr_dropped) begin
      dropped <= drop ? 8'd1 : 8'd0;
    end else if (drop && dropped != 8'hFF) begin
      dropped <= dropped + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (pop) begin
            hold  <= mem[rd_ptr];
            state <= S_HDR;
          end
        end
        S_HDR: if (tx_ready) state <= S_PC;
        S_PC: if (tx_ready) begin
          if (idx == PC_LAST) begin
            idx   <= '0;
            state <= S_INSN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_INSN: if (tx_ready) begin
          if (idx == INSN_LAST) begin
            idx   <= '0;
            state <= hold.we ? S_DATA : S_IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DATA: if (tx_ready) begin
          if (idx == PC_LAST) begin
            idx   <= '0;
            state <= S_IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid = (state != S_IDLE);
  assign busy     = (state != S_IDLE) | ~empty;

  // NOTE: default assignment first keeps this purely combinational (no latch).
  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_HDR:   tx_data = {hold.we, hold.prv, hold.addr};
      S_PC:    tx_data = hold.pc[8*idx +: 8];
      S_INSN:  tx_data = hold.insn[8*idx +: 8];
      S_DATA:  tx_data = hold.d[8*idx +: 8];
      default: tx_data = 8'h00;
    endcase
  end

endmodule
